// File: rtl/tick_timer_multi_if.sv
// tick_timer_multi control/status bundle.
// Master drives the channel controls; slave is the timer.
interface tick_timer_multi_if #(
  parameter int NUM_CH   = 3,
  parameter int PERIOD_W = 8
);
  logic                       enable;
  logic [NUM_CH*PERIOD_W-1:0] ch_period;
  logic [NUM_CH-1:0]          ch_oneshot;
  logic [NUM_CH-1:0]          ch_restart;
  logic                       base_tick;
  logic [NUM_CH-1:0]          ch_tick;
  logic [NUM_CH-1:0]          ch_busy;

  modport master (
    output enable,
    output ch_period,
    output ch_oneshot,
    output ch_restart,
    input  base_tick,
    input  ch_tick,
    input  ch_busy
  );

  modport slave (
    input  enable,
    input  ch_period,
    input  ch_oneshot,
    input  ch_restart,
    output base_tick,
    output ch_tick,
    output ch_busy
  );
endinterface

// File: rtl/tick_timer_multi.sv
// Shared base-tick prescaler feeding NUM_CH programmable
// channel dividers (continuous / one-shot, restart, pause).
module tick_timer_multi #(
  parameter int BASE_CYCLES = 1000000,
  parameter int NUM_CH      = 3,
  parameter int PERIOD_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  tick_timer_multi_if.slave bus
);
  localparam int CW = $clog2(BASE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BASE_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } st_t;

  logic [CW-1:0] r_pre;
  logic          r_base;
  logic          w_adv;

  // Channels only advance on a base tick seen while enabled
  assign w_adv         = r_base & bus.enable;
  assign bus.base_tick = r_base;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre  <= '0;
      r_base <= 1'b0;
    end else if (bus.enable) begin
      if (r_pre == LAST) begin
        r_pre  <= '0;
        r_base <= 1'b1;
      end else begin
        r_pre  <= r_pre + 1'b1;
        r_base <= 1'b0;
      end
    end else begin
      r_base <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    st_t                 r_st;
    st_t                 w_st_n;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] w_cnt_n;
    logic [PERIOD_W-1:0] r_per;
    logic [PERIOD_W-1:0] w_per_n;
    logic [PERIOD_W-1:0] w_prd;
    logic                r_os;
    logic                w_os_n;
    logic                r_tick;
    logic                w_tick_n;
    logic                w_rst;
    logic                w_run;
    logic                w_term;

    assign w_prd  = bus.ch_period[g*PERIOD_W +: PERIOD_W];
    assign w_rst  = bus.ch_restart[g];
    // Restart outranks a coincident terminal tick
    assign w_run  = (r_st == RUN) & w_adv & ~w_rst;
    assign w_term = (r_cnt == (r_per - PERIOD_W'(1)));

    always_comb begin
      w_st_n   = r_st;
      w_cnt_n  = r_cnt;
      w_per_n  = r_per;
      w_os_n   = r_os;
      w_tick_n = 1'b0;
      unique case (1'b1)
        w_rst: begin
          w_per_n = w_prd;
          w_os_n  = bus.ch_oneshot[g];
          w_cnt_n = '0;
          w_st_n  = (w_prd != '0) ? RUN : IDLE;
        end
        (w_run & w_term): begin
          w_cnt_n  = '0;
          w_tick_n = 1'b1;
          if (r_os) begin
            w_st_n = IDLE;
          end else begin
            w_per_n = w_prd;
            w_st_n  = (w_prd != '0) ? RUN : IDLE;
          end
        end
        (w_run & ~w_term): begin
          w_cnt_n = r_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_st   <= IDLE;
        r_cnt  <= '0;
        r_per  <= '0;
        r_os   <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        r_st   <= w_st_n;
        r_cnt  <= w_cnt_n;
        r_per  <= w_per_n;
        r_os   <= w_os_n;
        r_tick <= w_tick_n;
      end
    end

    assign bus.ch_tick[g] = r_tick;
    assign bus.ch_busy[g] = (r_st == RUN);
  end
endmodule

// File: tb/tb_tick_timer_multi.sv
// Bench for tick_timer_multi: directed timing checks plus
// randomized traffic against a base-tick counting model.
module tb_tick_timer_multi;
  localparam int BC = 10;
  localparam int NC = 3;
  localparam int PW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  tick_timer_multi_if #(.NUM_CH(NC), .PERIOD_W(PW)) bus ();

  tick_timer_multi #(
    .BASE_CYCLES(BC),
    .NUM_CH     (NC),
    .PERIOD_W   (PW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: base tick every BC enabled clocks; a channel
  // ticks once it has seen its period's worth of base ticks.
  int m_enclk = 0;
  bit m_base  = 0;
  bit m_armed [NC];
  bit m_os    [NC];
  int m_per   [NC];
  int m_seen  [NC];
  bit m_tick  [NC];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_enclk = 0;
      m_base  = 0;
      for (int i = 0; i < NC; i++) begin
        m_armed[i] = 0;
        m_os[i]    = 0;
        m_per[i]   = 0;
        m_seen[i]  = 0;
        m_tick[i]  = 0;
      end
    end else begin
      for (int i = 0; i < NC; i++) begin
        int p;
        p = int'(bus.ch_period[i*PW +: PW]);
        m_tick[i] = 0;
        if (bus.ch_restart[i]) begin
          m_per[i]   = p;
          m_os[i]    = bus.ch_oneshot[i];
          m_seen[i]  = 0;
          m_armed[i] = (p != 0);
        end else if (m_armed[i] && m_base && bus.enable) begin
          m_seen[i]++;
          if (m_seen[i] == m_per[i]) begin
            m_tick[i] = 1;
            m_seen[i] = 0;
            if (m_os[i]) begin
              m_armed[i] = 0;
            end else begin
              m_per[i]   = p;
              m_armed[i] = (p != 0);
            end
          end
        end
      end
      m_base = bus.enable && (((m_enclk + 1) % BC) == 0);
      if (bus.enable) m_enclk++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic wait_base(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.base_tick && n < 200);
  endtask

  task automatic wait_tick(input int ch, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ch_tick[ch] && n < 400);
  endtask

  task automatic pulse(input int ch, input int per, input bit os);
    logic [PW-1:0] pv;
    pv = PW'(per);
    #1;
    bus.ch_period[ch*PW +: PW] = pv;
    bus.ch_oneshot[ch]         = os;
    bus.ch_restart[ch]         = 1'b1;
    @(negedge clk);
    #1 bus.ch_restart[ch] = 1'b0;
  endtask

  function automatic int rnd_per();
    int r;
    r = int'($urandom % 16);
    if (r == 0) return 0;
    if (r == 1) return 255;
    return 1 + int'($urandom % 4);
  endfunction

  initial begin
    int n;
    int cnt;
    logic [PW-1:0] pv;
    bus.enable     = 1'b1;
    bus.ch_period  = '0;
    bus.ch_oneshot = '0;
    bus.ch_restart = '0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);

    fork
      forever begin
        logic [NC-1:0] et;
        logic [NC-1:0] eb;
        @(negedge clk);
        for (int i = 0; i < NC; i++) begin
          et[i] = m_tick[i];
          eb[i] = m_armed[i];
        end
        chk("base_tick", 32'(bus.base_tick), 32'(m_base));
        chk("ch_tick", 32'(bus.ch_tick), 32'(et));
        chk("ch_busy", 32'(bus.ch_busy), 32'(eb));
      end
    join_none

    chk("reset_outs",
        32'({bus.base_tick, bus.ch_tick, bus.ch_busy}), 0);
    #1 reset = 1'b1;
    wait_base(n);
    chk("first_base", n, 10);
    chk("idle_busy", 32'(bus.ch_busy), 0);
    wait_base(n);
    chk("base_spacing", n, 10);

    pulse(0, 3, 1'b0);
    wait_tick(0, n);
    chk("ch0_first_seen", 32'(n < 400), 1);
    wait_tick(0, n);
    chk("ch0_gap_p3", n, 30);
    chk("ch0_busy", 32'(bus.ch_busy[0]), 1);
    repeat (3) @(negedge clk);
    pv = 8'd5;
    #1 bus.ch_period[0 +: PW] = pv;
    wait_tick(0, n);
    chk("ch0_gap_before_change", 3 + n, 30);
    wait_tick(0, n);
    chk("ch0_gap_p5", n, 50);

    repeat (5) @(negedge clk);
    #1 bus.enable = 1'b0;
    repeat (25) @(negedge clk);
    #1 bus.enable = 1'b1;
    wait_tick(0, n);
    chk("ch0_gap_pause", 30 + n, 75);

    repeat (49) @(negedge clk);
    chk("term_base", 32'(bus.base_tick), 1);
    pulse(0, 5, 1'b0);
    chk("restart_wins", 32'(bus.ch_tick[0]), 0);
    wait_tick(0, n);
    chk("restart_gap", n, 50);

    pulse(1, 2, 1'b1);
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.ch_tick[1]) cnt++;
    end
    chk("ch1_oneshot_ticks", cnt, 1);
    chk("ch1_idle", 32'(bus.ch_busy[1]), 0);

    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_outs",
          32'({bus.base_tick, bus.ch_tick, bus.ch_busy}), 0);
    end
    #1 reset = 1'b1;
    wait_base(n);
    chk("base_after_reset", n, 10);
    chk("busy_after_reset", 32'(bus.ch_busy), 0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      bus.enable     = ($urandom % 8) != 0;
      bus.ch_restart = '0;
      for (int i = 0; i < NC; i++) begin
        if ($urandom % 10 == 0) begin
          pv = PW'(rnd_per());
          bus.ch_period[i*PW +: PW] = pv;
        end
        if ($urandom % 25 == 0) begin
          bus.ch_oneshot[i] = $urandom % 3 == 0;
          bus.ch_restart[i] = 1'b1;
        end
      end
      if (c == 1500) reset = 1'b0;
      if (c == 1502) reset = 1'b1;
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
